shifter_pipe: RTL and testbench
===============================

// Module: shifter_pipe
// PURPOSE
//   Pipelined, parametrised barrel shifter/rotator for the execute path. Supports left/right logical,
//   arithmetic-right and rotate-right modes. Uses a log2(WIDTH) stage decomposition with pipeline
//   registers every STAGES_PER_REG stages. Has valid/ready handshakes on both sides and a sideband tag.
//   Sits between operand read and writeback arbitration. Lets long shifts close timing at full clock rate.
// PARAMETERS
//   WIDTH           64  data width; power of two, >= 8
//   STAGES_PER_REG  2   log-shift stages per pipeline register; 1..SHAMT_W
//   TAG_W           4   width of pass-through tag (e.g. dest reg id)
//   (derived) SHAMT_W = $clog2(WIDTH); LAT = ceil(SHAMT_W/STAGES_PER_REG) (64/2 -> 3)
// PORTS
//   clk        in   1        clock, all state on rising edge
//   rst_n      in   1        synchronous reset, active-low
//   in_valid   in   1        input beat valid
//   in_ready   out  1        block can accept a beat this cycle
//   in_data    in   WIDTH    operand to shift
//   in_shamt   in   SHAMT_W  shift amount, 0..WIDTH-1
//   in_mode    in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR
//   in_tag     in   TAG_W    carried unchanged to out_tag
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer accepts result
//   out_data   out  WIDTH    shifted result
//   out_tag    out  TAG_W    tag of this result
//   out_zero   out  1        out_data == 0
// BEHAVIOUR
//   - Transfer occurs when valid && ready on the same edge. An input accepted at edge N is presented
//     at out_* after edge N+LAT-1 and no earlier, if nothing stalls it.
//   - Mode semantics for shamt s:
//     - SLL: d<<s, zero fill.
//     - SRL: d>>s, zero fill.
//     - SRA: d>>s, fill with d[WIDTH-1].
//     - ROR: (d>>s)|(d<<(WIDTH-s)). For s=0 the result equals d.
//   - Right modes: bit-reverse the operand, feed it through the left-shift network, then reverse back.
//     The fill bit is selected per mode. Each log stage k shifts by 2^k when shamt[k]=1, MSB stage first.
//   - Pipeline control:
//     - Each register stage holds a valid bit, plus data, shamt residue, mode, tag and fill bit.
//     - Stage i loads when it is empty or its contents move on this cycle (bubble-collapsing).
//     - in_ready = !v[0] || stage0 advances. This path is combinational from out_ready; there are no
//       other comb paths from input to output.
//   - Throughput is one result per cycle with out_ready held high. At most LAT beats are in flight.
//   - Backpressure: out_ready low holds out_* stable. Upstream stages fill, then in_ready deasserts.
//     No beat is dropped, duplicated or reordered.
//   - out_zero is registered with out_data. It is valid only when out_valid=1.
//   - Reset (rst_n=0 at an edge):
//     - All valid bits clear; out_valid=0, out_data=0, out_tag=0, out_zero=0.
//     - in_ready=0 while rst_n=0, and 1 on the first cycle after release.
//   - Reset mid-operation discards all in-flight beats with no partial output.
//   - in_data, in_shamt, in_mode and in_tag are ignored when in_valid=0. out_* are don't-care except
//     the reset values above.
//   - in_valid may drop without a transfer, so no hold rule is imposed upstream. out_valid, once high,
//     stays high until the transfer completes.
// STRUCTURE
//   - Shared package shifter_pkg holds:
//     - shift_mode_t enum {SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR=2'b11}.
//     - Function bitrev(WIDTH).
//   - Sub-module shifter_pipe_stage (params WIDTH, TAG_W, FIRST_K, NSTG):
//     - Applies NSTG log stages starting at bit FIRST_K.
//     - Contains one register stage with its valid/advance logic.
//   - Top instantiates LAT of them via generate and adds the input reverse and output reverse/fill mux.
// TESTING (WIDTH=64, STAGES_PER_REG=2, LAT=3)
//   1. SLL d=0x1, s=63 -> 0x8000_0000_0000_0000 at exactly LAT cycles. s=0 -> 0x1.
//   2. d=0x8000_0000_0000_0000, s=4: SRA -> 0xF800_0000_0000_0000, SRL -> 0x0800_0000_0000_0000.
//   3. ROR d=0x1 with s=1 -> 0x8000_0000_0000_0000 and s=0 -> 0x1.
//      SLL d=0x1, s=1 gives 0x2 with out_zero=0; SRL d=0x1, s=1 gives 0 with out_zero=1.
//   4. 8 back-to-back beats (tags 0..7), out_ready=1 -> 8 results on 8 consecutive cycles, in order.
//   5. Same as 4 with out_ready=0 for 6 cycles:
//      - in_ready drops after 3 accepted; out_* hold stable.
//      - All 8 results arrive in order with no loss or duplication.
//   6. 2 beats in flight, rst_n=0 for 1 cycle -> out_valid=0 next cycle, no result emitted.
//      The first beat after release completes normally.

Source files
------------

// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pkg
// Description : Shared types and helpers for the pipelined barrel shifter.
//               shift_mode_t encodes the four shift/rotate operations;
//               bitrev() reverses the low w bits of a vector so that right
//               shifts can reuse the left-shift network.
// Revision    : 1.0 - initial release
// ============================================================================
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_t;

  // Upper bound on the data width bitrev() can handle.
  localparam int BITREV_MAX_W = 256;
  localparam int BITREV_IDX_W = $clog2(BITREV_MAX_W);

  // Reverse bits [w-1:0] of d; bits at and above w return as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] d,
                                                     input int w);
    logic [BITREV_MAX_W-1:0] r;
    logic [BITREV_IDX_W-1:0] src;
    r = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) begin
        src = BITREV_IDX_W'(w - 1 - i);
        r[BITREV_IDX_W'(i)] = d[src];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shifter_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pipe_stage
// Description : NSTG log-shift stages (bit FIRST_K downward) followed by one
//               pipeline register with valid/ready control. The data is
//               always shifted left; right modes arrive bit-reversed, the
//               fill bit supplies the vacated bits, ROR wraps the top bits.
// Ports       : in_*  - upstream beat (valid/ready, data, shamt, mode, tag, fill)
//               out_* - registered beat to the next stage (valid/ready, ...)
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_pipe_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int TAG_W   = 4,
  parameter int FIRST_K = 5,
  parameter int NSTG    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [$clog2(WIDTH)-1:0]    in_shamt,
  input  logic [1:0]                  in_mode,
  input  logic [TAG_W-1:0]            in_tag,
  input  logic                        in_fill,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(WIDTH)-1:0]    out_shamt,
  output logic [1:0]                  out_mode,
  output logic [TAG_W-1:0]            out_tag,
  output logic                        out_fill
);

  localparam int SHAMT_W = $clog2(WIDTH);

  // Combinational log-shift chain: lvl[0] is the input, lvl[NSTG] the result.
  logic [NSTG:0][WIDTH-1:0] lvl;
  assign lvl[0] = in_data;

  for (genvar j = 0; j < NSTG; j++) begin : g_log
    localparam int K  = FIRST_K - j;
    localparam int SH = 1 << K;
    logic [WIDTH-1:0] w_low;
    // Bits entering at the bottom: wrapped top bits for ROR, else the fill bit.
    assign w_low = (in_mode == SH_ROR) ? (lvl[j] >> (WIDTH - SH))
                                       : ({WIDTH{in_fill}} & ~({WIDTH{1'b1}} << SH));
    assign lvl[j+1] = in_shamt[K] ? ((lvl[j] << SH) | w_low) : lvl[j];
  end

  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [SHAMT_W-1:0]   shamt_q, shamt_d;
  logic [1:0]           mode_q, mode_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 fill_q, fill_d;
  logic                 load;

  // Load when empty or when the held beat leaves this cycle (bubble collapse).
  assign load     = !valid_q || out_ready;
  assign in_ready = load;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    fill_d  = fill_q;
    if (load) begin
      valid_d = in_valid;
      data_d  = lvl[NSTG];
      shamt_d = in_shamt;
      mode_d  = in_mode;
      tag_d   = in_tag;
      fill_d  = in_fill;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      mode_q  <= '0;
      tag_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
      fill_q  <= fill_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_shamt = shamt_q;
  assign out_mode  = mode_q;
  assign out_tag   = tag_q;
  assign out_fill  = fill_q;

endmodule
`default_nettype wire

// File: rtl/shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pipe
// Description : Pipelined barrel shifter/rotator (SLL, SRL, SRA, ROR) with
//               valid/ready on both sides and a pass-through tag. LAT
//               register stages, each covering STAGES_PER_REG log stages.
//               WIDTH must be a power of two between 8 and 256.
// Ports       : clk, rst_n (sync, active-low)
//               in_valid/in_ready/in_data/in_shamt/in_mode/in_tag  - operand side
//               out_valid/out_ready/out_data/out_tag/out_zero      - result side
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH          = 64,
  parameter int STAGES_PER_REG = 2,
  parameter int TAG_W          = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [1:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_zero
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int LAT     = (SHAMT_W + STAGES_PER_REG - 1) / STAGES_PER_REG;

  // Index i is the input of register stage i; index LAT is the final output.
  logic [LAT:0]                v_s;
  logic [LAT:0]                rdy_s;
  logic [LAT:0][WIDTH-1:0]     data_s;
  logic [LAT:0][SHAMT_W-1:0]   shamt_s;
  logic [LAT:0][1:0]           mode_s;
  logic [LAT:0][TAG_W-1:0]     tag_s;
  logic [LAT:0]                fill_s;

  logic w_in_right;
  logic w_out_right;

  // Right modes are reversed on entry so every stage only ever shifts left.
  assign w_in_right = (in_mode != SH_SLL);
  assign v_s[0]     = in_valid;
  assign data_s[0]  = w_in_right ? WIDTH'(bitrev(BITREV_MAX_W'(in_data), WIDTH)) : in_data;
  assign shamt_s[0] = in_shamt;
  assign mode_s[0]  = in_mode;
  assign tag_s[0]   = in_tag;
  assign fill_s[0]  = (in_mode == SH_SRA) ? in_data[WIDTH-1] : 1'b0;

  // Ready ripples back from out_ready through every stage; rst_n gates it
  // so no beat is offered acceptance while the pipe is held in reset.
  assign rdy_s[LAT] = out_ready;
  assign in_ready   = rst_n && rdy_s[0];

  for (genvar i = 0; i < LAT; i++) begin : g_stage
    localparam int FK = SHAMT_W - 1 - i * STAGES_PER_REG;
    localparam int NS = (FK + 1 < STAGES_PER_REG) ? FK + 1 : STAGES_PER_REG;
    shifter_pipe_stage #(
      .WIDTH   (WIDTH),
      .TAG_W   (TAG_W),
      .FIRST_K (FK),
      .NSTG    (NS)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v_s[i]),
      .in_ready  (rdy_s[i]),
      .in_data   (data_s[i]),
      .in_shamt  (shamt_s[i]),
      .in_mode   (mode_s[i]),
      .in_tag    (tag_s[i]),
      .in_fill   (fill_s[i]),
      .out_valid (v_s[i+1]),
      .out_ready (rdy_s[i+1]),
      .out_data  (data_s[i+1]),
      .out_shamt (shamt_s[i+1]),
      .out_mode  (mode_s[i+1]),
      .out_tag   (tag_s[i+1]),
      .out_fill  (fill_s[i+1])
    );
  end

  // Undo the entry reversal for right modes; pure wiring plus a mux off the
  // last register, so outputs stay register-driven.
  assign w_out_right = (mode_s[LAT] != SH_SLL);
  assign out_valid   = v_s[LAT];
  assign out_data    = w_out_right ? WIDTH'(bitrev(BITREV_MAX_W'(data_s[LAT]), WIDTH))
                                   : data_s[LAT];
  assign out_tag     = tag_s[LAT];
  // Reversal preserves zero-ness; gating with valid keeps the reset value low.
  assign out_zero    = v_s[LAT] && (data_s[LAT] == '0);

endmodule
`default_nettype wire

// File: tb/tb_shifter_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_shifter_pipe
// Description : Directed self-checking bench for shifter_pipe (WIDTH=64,
//               STAGES_PER_REG=2, LAT=3). Inputs change 1ns after the rising
//               edge, outputs are sampled 1-2ns after it, in_ready at 3ns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shifter_pipe;

  localparam int WIDTH = 64;
  localparam int TAG_W = 4;
  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [5:0]       in_shamt = '0;
  logic [1:0]       in_mode = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;

  int n_assert = 0;
  int n_fail   = 0;

  logic [TAG_W-1:0] tag_ctr = '0;

  logic [63:0]      got_data [16];
  logic [TAG_W-1:0] got_tag  [16];
  int               got_cyc  [16];
  int               n_got;
  int               stall_seen;
  int               first_block;

  shifter_pipe #(.WIDTH(WIDTH), .STAGES_PER_REG(2), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end (observed timeout, expected completion)");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single beat with out_ready high; starts and ends 1ns after a rising edge.
  task automatic run1(input string tag, input logic [63:0] d, input int s,
                      input logic [1:0] m, input logic [63:0] exp, input logic expz);
    logic [TAG_W-1:0] t;
    t        = tag_ctr;
    tag_ctr  = tag_ctr + 1'b1;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = 6'(s);
    in_mode  = m;
    in_tag   = t;
    #2;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;              // accepted at this edge (N)
    in_valid = 1'b0;
    @(posedge clk); #1;              // after N+1: must not be out yet
    chk({tag, ".early"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;              // after N+2 = N+LAT-1
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".data"}, out_data, exp);
    chk({tag, ".tag"}, 64'(out_tag), 64'(t));
    chk({tag, ".zero"}, 64'(out_zero), 64'(expz));
    @(posedge clk); #1;              // result consumed
  endtask

  // Beats i=0..n-1: SLL of 1 by i, tag i.
  task automatic drive_stream(input int n);
    int  i = 0;
    logic acc;
    first_block = -1;
    for (int g = 0; g < 60 && i < n; g++) begin
      in_valid = 1'b1;
      in_data  = 64'h1;
      in_shamt = 6'(i);
      in_mode  = M_SLL;
      in_tag   = TAG_W'(i);
      #2;
      acc = in_ready;
      if (!acc && first_block < 0) first_block = i;
      @(posedge clk); #1;
      if (acc) i++;
    end
    in_valid = 1'b0;
    chk("stream.all_accepted", 64'(i), 64'(n));
  endtask

  // Records every handshake; while stalled the head beat (tag 0) must hold.
  task automatic collect(input int ncyc);
    n_got = 0;
    stall_seen = 0;
    for (int c = 0; c < ncyc; c++) begin
      #1;
      if (out_valid && out_ready && n_got < 16) begin
        got_data[n_got] = out_data;
        got_tag[n_got]  = out_tag;
        got_cyc[n_got]  = c;
        n_got++;
      end
      if (out_valid && !out_ready) begin
        stall_seen++;
        chk("stall.hold_data", out_data, 64'h1);
        chk("stall.hold_tag", 64'(out_tag), 64'd0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_stream(input string tag, input int first_cyc);
    chk({tag, ".count"}, 64'(n_got), 64'd8);
    for (int k = 0; k < 8 && k < n_got; k++) begin
      chk($sformatf("%s.data%0d", tag, k), got_data[k], 64'h1 << k);
      chk($sformatf("%s.tag%0d", tag, k), 64'(got_tag[k]), 64'(k));
      chk($sformatf("%s.cyc%0d", tag, k), 64'(got_cyc[k]), 64'(first_cyc + k));
    end
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.out_data", out_data, 64'd0);
    chk("reset.out_tag", 64'(out_tag), 64'd0);
    chk("reset.out_zero", 64'(out_zero), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("release.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed single beats
    run1("sll63",  64'h1, 63, M_SLL, 64'h8000_0000_0000_0000, 1'b0);
    run1("sll0",   64'h1,  0, M_SLL, 64'h1, 1'b0);
    run1("sra4",   64'h8000_0000_0000_0000, 4, M_SRA, 64'hF800_0000_0000_0000, 1'b0);
    run1("srl4",   64'h8000_0000_0000_0000, 4, M_SRL, 64'h0800_0000_0000_0000, 1'b0);
    run1("ror1",   64'h1, 1, M_ROR, 64'h8000_0000_0000_0000, 1'b0);
    run1("ror0",   64'h1, 0, M_ROR, 64'h1, 1'b0);
    run1("sll1",   64'h1, 1, M_SLL, 64'h2, 1'b0);
    run1("srl1z",  64'h1, 1, M_SRL, 64'h0, 1'b1);
    run1("ror8",   64'h0123_4567_89AB_CDEF, 8, M_ROR, 64'hEF01_2345_6789_ABCD, 1'b0);
    run1("ror63",  64'h8000_0000_0000_0001, 63, M_ROR, 64'h0000_0000_0000_0003, 1'b0);
    run1("sra63n", 64'h8000_0000_0000_0000, 63, M_SRA, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run1("sra63p", 64'h7000_0000_0000_0000, 63, M_SRA, 64'h0, 1'b1);
    run1("sll32",  64'hFFFF_FFFF_FFFF_FFFF, 32, M_SLL, 64'hFFFF_FFFF_0000_0000, 1'b0);
    run1("srl60",  64'hFF00_0000_0000_0000, 60, M_SRL, 64'hF, 1'b0);

    // Back-to-back stream, no backpressure: beat 0 accepted at the end of
    // cycle 0, visible in cycle 3, one result per cycle after that.
    out_ready = 1'b1;
    fork
      drive_stream(8);
      collect(30);
    join
    check_stream("b2b", 3);
    chk("b2b.no_block", 64'(first_block), 64'hFFFF_FFFF_FFFF_FFFF);

    // Same stream with out_ready low for cycles 0..5: three beats fill the
    // pipe, head beat is held in cycles 3..5, draining starts in cycle 6.
    out_ready = 1'b0;
    fork
      drive_stream(8);
      collect(30);
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check_stream("bp", 6);
    chk("bp.block_after", 64'(first_block), 64'd3);
    chk("bp.stall_cycles", 64'(stall_seen), 64'd3);

    // Reset with two beats in flight
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'h1; in_shamt = 6'd5; in_mode = M_SLL; in_tag = 4'hA;
    @(posedge clk); #1;
    in_data = 64'h3; in_tag = 4'hB;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.out_data", out_data, 64'd0);
    chk("midrst.in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst.quiet%0d", c), 64'(out_valid), 64'd0);
    end
    run1("post_rst", 64'h0000_0000_0000_00F0, 4, M_SRL, 64'hF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
